mips_data_mem_io: RTL and testbench

//   Memory-stage data memory plus memory-mapped peripherals for the pipelined MIPS CPU.

---
 rtl/mips_data_mem_io.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mips_data_mem_io.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem_io.sv
// MEM-stage data RAM with memory-mapped timer, LED/switch/7-seg registers and optional 8N1 UART.
// Define MIPS_DATA_MEM_UART_EN to build the UART; otherwise its addresses read 0 and Uart_Tx idles high.
module mips_data_mem_io #(
    parameter int RAM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic [7:0]  switch,
    input  logic        Uart_Rx,
    output logic [31:0] readdata,
    output logic [7:0]  led,
    output logic [17:0] tube,
    output logic        Uart_Tx,
    output logic        irq,
    output logic        if_continue
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    localparam logic [29:0] A_TH   = 30'h1000_0000;
    localparam logic [29:0] A_TL   = 30'h1000_0001;
    localparam logic [29:0] A_TCON = 30'h1000_0002;
    localparam logic [29:0] A_LED  = 30'h1000_0003;
    localparam logic [29:0] A_SW   = 30'h1000_0004;
    localparam logic [29:0] A_TUBE = 30'h1000_0005;
    localparam logic [29:0] A_TXD  = 30'h1000_0006;
    localparam logic [29:0] A_RXD  = 30'h1000_0007;
    localparam logic [29:0] A_UCON = 30'h1000_0008;

    logic [29:0]      word_addr;
    logic             ram_sel;
    logic [IDX_W-1:0] ram_idx;
    logic             unused_addr_bits;

    assign word_addr        = address[31:2];
    assign ram_sel          = (address >> (IDX_W + 2)) == 32'd0;
    assign ram_idx          = address[IDX_W+1:2];
    assign unused_addr_bits = ^address[1:0];

    // ---------------- data RAM (contents survive reset) ----------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (write_enable && ram_sel)
            ram[ram_idx] <= writedata;
    end

    // ---------------- timer and board registers ----------------
    logic [31:0] th_reg;
    logic [31:0] tl_reg;
    logic [2:0]  tcon_reg;
    logic [7:0]  led_reg;
    logic [17:0] tube_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_reg   <= 32'd0;
            tl_reg   <= 32'd0;
            tcon_reg <= 3'd0;
            led_reg  <= 8'd0;
            tube_reg <= 18'd0;
        end else begin
            if (tcon_reg[0]) begin
                if (tl_reg == 32'hFFFF_FFFF) begin
                    tl_reg      <= th_reg;
                    tcon_reg[2] <= tcon_reg[1] | tcon_reg[2];
                end else begin
                    tl_reg <= tl_reg + 32'd1;
                end
            end
            // CPU writes come last so they override the count update in the same cycle
            if (write_enable) begin
                case (word_addr)
                    A_TH:    th_reg   <= writedata;
                    A_TL:    tl_reg   <= writedata;
                    A_TCON:  tcon_reg <= writedata[2:0];
                    A_LED:   led_reg  <= writedata[7:0];
                    A_TUBE:  tube_reg <= writedata[17:0];
                    default: ;
                endcase
            end
        end
    end

    assign led  = led_reg;
    assign tube = tube_reg;
    assign irq  = tcon_reg[2];

`ifdef MIPS_DATA_MEM_UART_EN
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TICK_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     tx_state_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    txd_reg;
    logic          tx_out_reg;
    logic          tx_busy;
    logic          wr_txd;

    assign wr_txd  = write_enable && (word_addr == A_TXD);
    assign tx_busy = (tx_state_reg != TX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            txd_reg      <= 8'd0;
            tx_out_reg   <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (wr_txd) begin
                        txd_reg      <= writedata[7:0];
                        tx_out_reg   <= 1'b0;
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == TICK_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= 3'd0;
                        tx_out_reg   <= txd_reg[0];
                        tx_state_reg <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == TICK_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            tx_out_reg   <= 1'b1;
                            tx_state_reg <= TX_STOP;
                        end else begin
                            tx_bit_reg <= tx_bit_reg + 3'd1;
                            tx_out_reg <= txd_reg[tx_bit_reg + 3'd1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_reg == TICK_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    assign Uart_Tx     = tx_out_reg;
    assign if_continue = ~tx_busy;

    // Two-flop synchroniser on the asynchronous serial input
    logic [1:0] rx_sync_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rx_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    rx_sync_reg[gi] <= 1'b1;
                else
                    rx_sync_reg[gi] <= (gi == 0) ? Uart_Rx : rx_sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    rx_state_t     rx_state_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;
    logic [7:0]    rxd_reg;
    logic          rx_valid_reg;
    logic          rx_prev_reg;
    logic          rx_line;
    logic          rd_rxd;

    assign rx_line = rx_sync_reg[1];
    assign rd_rxd  = read_enable && (word_addr == A_RXD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
            rxd_reg      <= 8'd0;
            rx_valid_reg <= 1'b0;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_prev_reg <= rx_line;
            // A frame completing in the same cycle as the clearing read keeps the flag set
            if (rd_rxd)
                rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_line) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == TICK_HALF) begin
                        rx_cnt_reg <= '0;
                        rx_bit_reg <= 3'd0;
                        rx_state_reg <= rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == TICK_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                        else
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == TICK_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_line) begin
                            rxd_reg      <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end
`else
    logic unused_uart_rx;

    assign unused_uart_rx = Uart_Rx;
    assign Uart_Tx        = 1'b1;
    assign if_continue    = 1'b1;
`endif

    // ---------------- combinational read mux ----------------
    always_comb begin
        readdata = 32'd0;
        if (read_enable) begin
            if (ram_sel) begin
                readdata = ram[ram_idx];
            end else begin
                case (word_addr)
                    A_TH:    readdata = th_reg;
                    A_TL:    readdata = tl_reg;
                    A_TCON:  readdata = {29'd0, tcon_reg};
                    A_LED:   readdata = {24'd0, led_reg};
                    A_SW:    readdata = {24'd0, switch};
                    A_TUBE:  readdata = {14'd0, tube_reg};
`ifdef MIPS_DATA_MEM_UART_EN
                    A_TXD:   readdata = {24'd0, txd_reg};
                    A_RXD:   readdata = {24'd0, rxd_reg};
                    A_UCON:  readdata = {28'd0, rx_valid_reg, 2'b00, tx_busy};
`endif
                    default: readdata = 32'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem_io.sv
// Scoreboard bench for mips_data_mem_io: RAM, board registers, timer reload/irq, UART (when built) and reset.
module tb_mips_data_mem_io;

    localparam int CPB = 4;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_TUBE = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_RXD  = 32'h4000_001C;
    localparam logic [31:0] A_UCON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [7:0]  switch_in;
    logic        uart_rx;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic [17:0] tube;
    logic        uart_tx;
    logic        irq;
    logic        if_continue;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        tx_q[$];

    mips_data_mem_io #(.RAM_WORDS(256), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .writedata   (writedata),
        .switch      (switch_in),
        .Uart_Rx     (uart_rx),
        .readdata    (readdata),
        .led         (led),
        .tube        (tube),
        .Uart_Tx     (uart_tx),
        .irq         (irq),
        .if_continue (if_continue)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Called just after a rising edge; the write lands on the next edge
    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        address      = addr;
        writedata    = data;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        address     = addr;
        read_enable = 1'b1;
        #1;
        check_val(tag, readdata, exp_q.pop_front());
        read_enable = 1'b0;
    endtask

    // Read held across a clock edge so side effects (RXD flag clear) take place
    task automatic read_edge(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        address     = addr;
        read_enable = 1'b1;
        #1;
        check_val(tag, readdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        read_enable = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = 32'd0;
        writedata    = 32'd0;
        switch_in    = 8'h3C;
        uart_rx      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_led", {24'd0, led}, 32'd0);
        check_val("rst_tube", {14'd0, tube}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_tx", {31'd0, uart_tx}, 32'd1);
        check_val("rst_ifc", {31'd0, if_continue}, 32'd1);
        peek("rst_tcon", A_TCON, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // RAM
        cpu_write(32'h0000_0010, 32'h1234_5678);
        peek("ram_10", 32'h0000_0010, 32'h1234_5678);
        cpu_write(32'h0000_03FC, 32'hDEAD_BEEF);
        peek("ram_3fc", 32'h0000_03FC, 32'hDEAD_BEEF);
        peek("ram_10_keep", 32'h0000_0010, 32'h1234_5678);
        peek("unmapped_400", 32'h0000_0400, 32'd0);
        exp_q.push_back(32'd0);
        address = 32'h0000_0010;
        #1;
        check_val("read_disabled", readdata, exp_q.pop_front());

        // board registers
        cpu_write(A_LED, 32'hFFFF_FFA5);
        check_val("led_out", {24'd0, led}, 32'h0000_00A5);
        peek("led_rd", A_LED, 32'h0000_00A5);
        cpu_write(A_TUBE, 32'h0003_FFFF);
        check_val("tube_out", {14'd0, tube}, 32'h0003_FFFF);
        peek("sw_rd", A_SW, 32'h0000_003C);
        cpu_write(A_SW, 32'h0000_00FF);
        peek("sw_ro", A_SW, 32'h0000_003C);
        peek("unmapped_24", 32'h4000_0024, 32'd0);

        // timer reload and interrupt
        cpu_write(A_TH, 32'hFFFF_FFFE);
        cpu_write(A_TL, 32'hFFFF_FFFE);
        cpu_write(A_TCON, 32'd3);
        check_val("tmr_irq0", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        peek("tmr_tl_ff", A_TL, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check_val("tmr_irq1", {31'd0, irq}, 32'd1);
        peek("tmr_reload", A_TL, 32'hFFFF_FFFE);
        peek("tmr_tcon7", A_TCON, 32'd7);
        cpu_write(A_TCON, 32'd1);
        check_val("tmr_irq_clr", {31'd0, irq}, 32'd0);
        peek("tmr_tcon1", A_TCON, 32'd1);
        cpu_write(A_TCON, 32'd0);

`ifdef MIPS_DATA_MEM_UART_EN
        // UART transmit: start, 0x55 LSB first, stop
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(i[0] ? 1'b0 : 1'b1);
        tx_q.push_back(1'b1);
        cpu_write(A_TXD, 32'h0000_0055);
        @(posedge clk);
        #1;
        check_val("tx_bit0", {31'd0, uart_tx}, {31'd0, tx_q.pop_front()});
        check_val("tx_ifc_busy", {31'd0, if_continue}, 32'd0);
        peek("tx_con_busy", A_UCON, 32'd1);
        cpu_write(A_TXD, 32'h0000_00FF);
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(posedge clk);
            #1;
            check_val($sformatf("tx_bit%0d", k), {31'd0, uart_tx}, {31'd0, tx_q.pop_front()});
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("tx_ifc_idle", {31'd0, if_continue}, 32'd1);
        peek("tx_con_idle", A_UCON, 32'd0);
        peek("txd_last", A_TXD, 32'h0000_0055);

        // UART receive
        send_rx(8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        peek("rx_con_valid", A_UCON, 32'd8);
        read_edge("rx_data", A_RXD, 32'h0000_003C);
        peek("rx_con_clr", A_UCON, 32'd0);
        send_rx(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        peek("rx_badstop_con", A_UCON, 32'd0);
        peek("rx_badstop_rxd", A_RXD, 32'h0000_003C);
`else
        cpu_write(A_TXD, 32'h0000_0055);
        check_val("nouart_tx", {31'd0, uart_tx}, 32'd1);
        check_val("nouart_ifc", {31'd0, if_continue}, 32'd1);
        peek("nouart_txd", A_TXD, 32'd0);
        peek("nouart_con", A_UCON, 32'd0);
`endif

        // reset in the middle of a timer count and a TX frame
        cpu_write(A_LED, 32'h0000_005A);
        cpu_write(A_TH, 32'h0000_0100);
        cpu_write(A_TL, 32'h0000_0200);
        cpu_write(A_TCON, 32'd7);
`ifdef MIPS_DATA_MEM_UART_EN
        cpu_write(A_TXD, 32'h0000_0000);
`endif
        repeat (6) @(posedge clk);
        #1;
        check_val("pre_rst_irq", {31'd0, irq}, 32'd1);
`ifdef MIPS_DATA_MEM_UART_EN
        check_val("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
`endif
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_tx", {31'd0, uart_tx}, 32'd1);
        check_val("arst_irq", {31'd0, irq}, 32'd0);
        check_val("arst_led", {24'd0, led}, 32'd0);
        check_val("arst_ifc", {31'd0, if_continue}, 32'd1);
        peek("arst_th", A_TH, 32'd0);
        peek("arst_tl", A_TL, 32'd0);
        peek("arst_tcon", A_TCON, 32'd0);
        peek("arst_ram_kept", 32'h0000_0010, 32'h1234_5678);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        peek("post_rst_tl", A_TL, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
